// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers to flag RAW/WAW hazards and select forwarding.
// Define HAZARD_FORWARDING_EN to stall only on load-use and report forwarding sources instead.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int STALL_CW   = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 issue_valid,
  input  logic [REG_AW-1:0]                    issue_rs1,
  input  logic [REG_AW-1:0]                    issue_rs2,
  input  logic [REG_AW-1:0]                    issue_rd,
  input  logic                                 issue_we,
  input  logic                                 issue_is_load,
  input  logic [NUM_STAGES-1:0]                stage_adv,
  input  logic                                 flush,
  output logic                                 no_hazard,
  output logic                                 issue_accept,
  output logic                                 rs1_hazard,
  output logic                                 rs2_hazard,
  output logic                                 rd_hazard,
  output logic [$clog2(NUM_STAGES+1)-1:0]      fwd_rs1_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0]      fwd_rs2_sel,
  output logic [$clog2(NUM_STAGES+1)-1:0]      busy_cnt,
  output logic [STALL_CW-1:0]                  stall_cycles
);
  localparam int FW = $clog2(NUM_STAGES+1);
  logic [NUM_STAGES-1:0] r_valid, r_we, r_ld;
  logic [REG_AW-1:0]     r_rd [NUM_STAGES];
  logic [STALL_CW-1:0]   r_stall;
  logic [NUM_STAGES-1:0] w_m1, w_m2, w_md;
  logic                  w_inc;
  logic                  w_unused;
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_m1[i] = r_valid[i] & r_we[i] & (r_rd[i] != '0) & (r_rd[i] == issue_rs1);
      w_m2[i] = r_valid[i] & r_we[i] & (r_rd[i] != '0) & (r_rd[i] == issue_rs2);
      w_md[i] = r_valid[i] & r_we[i] & (r_rd[i] != '0) & (r_rd[i] == issue_rd);
    end
  end
`ifdef HAZARD_FORWARDING_EN
  // Descending scan so the youngest (lowest index) match is written last and wins.
  always_comb begin
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
    for (int i = NUM_STAGES-1; i >= 0; i--) begin
      if (w_m1[i]) fwd_rs1_sel = FW'(i+1);
      if (w_m2[i]) fwd_rs2_sel = FW'(i+1);
    end
  end
  assign rs1_hazard = w_m1[0] & r_ld[0];
  assign rs2_hazard = w_m2[0] & r_ld[0];
  assign rd_hazard  = 1'b0;
  assign w_unused   = ^{r_ld, w_md};
`else
  assign fwd_rs1_sel = '0;
  assign fwd_rs2_sel = '0;
  assign rs1_hazard  = |w_m1;
  assign rs2_hazard  = |w_m2;
  assign rd_hazard   = |w_md;
  assign w_unused    = ^{r_ld, issue_is_load};
`endif
  assign no_hazard    = ~(rs1_hazard | rs2_hazard | rd_hazard);
  assign issue_accept = issue_valid & no_hazard & ~flush;
  assign w_inc        = issue_valid & ~no_hazard & ~flush;
  assign stall_cycles = r_stall;
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NUM_STAGES; i++) busy_cnt = busy_cnt + FW'(r_valid[i]);
  end
  // Payload fields are not reset: every consumer qualifies them with valid.
  always_ff @(posedge clk) begin
    if (rst || flush) r_valid <= '0;
    else begin
      r_valid[0] <= issue_accept ? 1'b1 : (stage_adv[0] ? 1'b0 : r_valid[0]);
      for (int i = 1; i < NUM_STAGES; i++)
        r_valid[i] <= stage_adv[i-1] ? r_valid[i-1] : (stage_adv[i] ? 1'b0 : r_valid[i]);
    end
    if (issue_accept) begin
      r_rd[0] <= issue_rd;
      r_we[0] <= issue_we;
      r_ld[0] <= issue_is_load;
    end
    for (int i = 1; i < NUM_STAGES; i++)
      if (stage_adv[i-1]) begin
        r_rd[i] <= r_rd[i-1];
        r_we[i] <= r_we[i-1];
        r_ld[i] <= r_ld[i-1];
      end
    r_stall <= (rst || !w_inc) ? '0 : (&r_stall ? r_stall : r_stall + STALL_CW'(1));
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus checked every cycle against a behavioural scoreboard model.
module tb_hazard_scoreboard;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 0, rst = 0;
  logic iv = 0, we = 0, ld = 0, flush = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [2:0] adv = 0;
  logic no_hazard, issue_accept, rs1_hazard, rs2_hazard, rd_hazard;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel, busy_cnt;
  logic [7:0] stall_cycles;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  typedef struct {logic v; logic [4:0] rd; logic we; logic ld;} ent_t;
  ent_t m[3];
  int m_stall = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_rs1(rs1), .issue_rs2(rs2),
    .issue_rd(rd), .issue_we(we), .issue_is_load(ld), .stage_adv(adv), .flush(flush),
    .no_hazard(no_hazard), .issue_accept(issue_accept), .rs1_hazard(rs1_hazard),
    .rs2_hazard(rs2_hazard), .rd_hazard(rd_hazard), .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel), .busy_cnt(busy_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic int young(input logic [4:0] r);
    for (int k = 0; k < 3; k++)
      if (m[k].v && m[k].we && r != 0 && m[k].rd == r) return k;
    return -1;
  endfunction
  function automatic bit e_haz(input logic [4:0] r, input bit is_rd);
    if (FWD) return !is_rd && young(r) == 0 && m[0].ld;
    return young(r) >= 0;
  endfunction
  function automatic int e_fwd(input logic [4:0] r);
    return FWD ? young(r) + 1 : 0;
  endfunction
  function automatic bit e_nh();
    return !(e_haz(rs1, 0) || e_haz(rs2, 0) || e_haz(rd, 1));
  endfunction
  function automatic int e_busy();
    int c = 0;
    for (int k = 0; k < 3; k++) c += int'(m[k].v);
    return c;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    ent_t n[3];
    bit nh;
    if (rst) begin
      for (int k = 0; k < 3; k++) m[k].v = 0;
      m_stall = 0;
    end else begin
      nh = e_nh();
      m_stall = (iv && !nh && !flush) ? (m_stall == 255 ? 255 : m_stall + 1) : 0;
      n = m;
      if (flush) for (int k = 0; k < 3; k++) n[k].v = 0;
      else begin
        if (iv && nh) n[0] = '{1'b1, rd, we, ld};
        else if (adv[0]) n[0].v = 0;
        for (int k = 1; k < 3; k++)
          if (adv[k-1]) n[k] = m[k-1];
          else if (adv[k]) n[k].v = 0;
      end
      m = n;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("cmp_rs1_hazard", rs1_hazard, e_haz(rs1, 0));
      chk("cmp_rs2_hazard", rs2_hazard, e_haz(rs2, 0));
      chk("cmp_rd_hazard", rd_hazard, e_haz(rd, 1));
      chk("cmp_no_hazard", no_hazard, e_nh());
      chk("cmp_issue_accept", issue_accept, iv && e_nh() && !flush);
      chk("cmp_fwd_rs1", fwd_rs1_sel, e_fwd(rs1));
      chk("cmp_fwd_rs2", fwd_rs2_sel, e_fwd(rs2));
      chk("cmp_busy", busy_cnt, e_busy());
      chk("cmp_stall", stall_cycles, m_stall);
    end
  end

  task automatic step(input bit v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input bit w, input bit l, input logic [2:0] ad, input bit f);
    @(negedge clk);
    rst = 0; iv = v; rs1 = a; rs2 = b; rd = d; we = w; ld = l; adv = ad; flush = f;
    #3;
  endtask

  initial begin
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk);
    chk_en = 1;
    step(0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk("idle_no_hazard", no_hazard, 1);
    chk("idle_busy", busy_cnt, 0);
    chk("idle_stall", stall_cycles, 0);
    chk("idle_fwd", fwd_rs1_sel, 0);
    step(1, 0, 0, 5, 1, 0, 3'b000, 0);
    chk("issue_rd5_accept", issue_accept, 1);
    for (int h = 0; h < 4; h++) begin
      step(1, 5, 0, 1, 1, 0, 3'b000, 0);
      chk("raw_rs1_hazard", rs1_hazard, FWD ? 0 : 1);
      chk("raw_stall_count", stall_cycles, FWD ? 0 : h);
    end
    step(0, 5, 0, 0, 0, 0, 3'b001, 0);
    chk("adv0_stall", stall_cycles, FWD ? 0 : 4);
    step(0, 5, 0, 0, 0, 0, 3'b010, 0);
    chk("adv1_stall_clear", stall_cycles, 0);
    step(0, 5, 0, 0, 0, 0, 3'b100, 0);
    chk("retiring_still_hazard", rs1_hazard, FWD ? 0 : 1);
    step(0, 5, 0, 0, 0, 0, 3'b000, 0);
    chk("retired_no_hazard", no_hazard, 1);
    chk("retired_busy", busy_cnt, 0);
    step(1, 0, 0, 0, 1, 0, 3'b000, 0);
    step(1, 0, 0, 0, 1, 0, 3'b000, 0);
    chk("x0_no_hazard", no_hazard, 1);
    chk("x0_busy", busy_cnt, 1);
    step(0, 0, 0, 0, 0, 0, 3'b000, 1);
    step(1, 0, 0, 7, 1, 0, 3'b000, 0);
    step(0, 0, 0, 0, 0, 0, 3'b001, 0);
    step(0, 0, 0, 0, 0, 0, 3'b010, 0);
    step(1, 0, 0, 7, 1, 0, 3'b000, 0);
    step(0, 7, 0, 0, 0, 0, 3'b000, 0);
    chk("youngest_fwd_sel", fwd_rs1_sel, FWD ? 1 : 0);
    chk("youngest_no_hazard", no_hazard, FWD ? 1 : 0);
    chk("youngest_busy", busy_cnt, FWD ? 2 : 1);
    step(0, 0, 0, 0, 0, 0, 3'b000, 1);
    step(1, 0, 0, 7, 1, 1, 3'b000, 0);
    step(0, 7, 7, 7, 0, 0, 3'b000, 0);
    chk("load_use_rs1", rs1_hazard, 1);
    chk("load_use_rs2", rs2_hazard, 1);
    chk("load_use_rd", rd_hazard, FWD ? 0 : 1);
    chk("load_use_fwd", fwd_rs1_sel, FWD ? 1 : 0);
    step(0, 0, 0, 0, 0, 0, 3'b000, 1);
    step(1, 0, 0, 1, 1, 0, 3'b000, 0);
    step(1, 0, 0, 2, 1, 0, 3'b001, 0);
    step(1, 0, 0, 3, 1, 0, 3'b011, 0);
    step(0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk("fill_busy", busy_cnt, 3);
    step(1, 0, 0, 4, 1, 0, 3'b111, 1);
    chk("flush_accept", issue_accept, 0);
    step(0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk("flush_busy", busy_cnt, 0);
    step(0, 0, 0, 0, 0, 0, 3'b111, 0);
    step(0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk("adv_invalid_busy", busy_cnt, 0);
    step(1, 0, 0, 1, 1, 0, 3'b000, 0);
    step(1, 0, 0, 2, 1, 0, 3'b001, 0);
    @(negedge clk);
    rst = 1; iv = 1; rd = 3; adv = 3'b111;
    #3;
    step(0, 0, 0, 0, 0, 0, 3'b000, 0);
    chk("midrst_busy", busy_cnt, 0);
    chk("midrst_no_hazard", no_hazard, 1);
    step(1, 0, 0, 9, 1, 1, 3'b000, 0);
    for (int j = 0; j < 300; j++) step(1, 9, 0, 0, 0, 0, 3'b000, 0);
    step(1, 9, 0, 0, 0, 0, 3'b000, 0);
    chk("stall_saturate", stall_cycles, 255);
    step(0, 9, 0, 0, 0, 0, 3'b000, 0);
    chk("stall_release_pre", stall_cycles, 255);
    step(0, 9, 0, 0, 0, 0, 3'b000, 0);
    chk("stall_release_zero", stall_cycles, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
